alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single 32-bit combinational ALU between two requesters: port 0 is the main execute datapath, port 1 is the branch/address unit. Each port uses a valid/ready request channel and a valid/ready response channel. A 2-way round-robin arbiter grants at most one request per cycle and drives the ALU inputs from the granted request. The ALU result and Zero flag are captured into a per-port response register.

Parameters:
DATA_WIDTH, 32, operand/result width
PRIORITY_RESET, 0, port that wins the first tie after reset (0 or 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_op1  in  DATA_WIDTH  port 0 Operand1
req0_op2  in  DATA_WIDTH  port 0 Operand2
req0_ctrl  in  2  port 0 ALU control (00 AND, 01 OR, 10 ADD, 11 SUB)
rsp0_valid  out  1  port 0 response valid
rsp0_ready  in  1  port 0 response consumed
rsp0_result  out  DATA_WIDTH  port 0 captured ALU result
rsp0_zero  out  1  port 0 captured Zero flag
req1_*/rsp1_*  same set and widths as port 0, for port 1
alu_op1  out  DATA_WIDTH  to ALU Operand1
alu_op2  out  DATA_WIDTH  to ALU Operand2
alu_ctrl  out  2  to ALU ALUControl
alu_result  in  DATA_WIDTH  from ALU ALUResult
alu_zero  in  1  from ALU Zero

Behaviour:
- Reset (clk edge with reset=1): rsp*_valid=0, rsp*_result=0, rsp*_zero=0, pending flags cleared. last_grant is set so that PRIORITY_RESET wins the next tie. Reset overrides all other events in that cycle.
- Eligibility: elig_i = reqi_valid & !pend_i. pend_i mirrors rspi_valid. There is no same-cycle bypass: a port with an unconsumed response is never granted, even if rspi_ready=1 in that cycle.
- Grant (combinational):
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port != last_grant.
  - reqi_ready = grant_i. reqi_ready may depend combinationally on reqi_valid.
- ALU drive (combinational):
  - Granted: alu_op1/op2/ctrl = granted port's operands.
  - No grant: alu_op1=0, alu_op2=0, alu_ctrl=00.
- Capture (clk edge, accept at cycle T):
  - rspi_result <= alu_result, rspi_zero <= alu_zero, rspi_valid <= 1.
  - last_grant <= i.
  - Latency: request accepted at T gives response valid at T+1.
- Response hold: rspi_valid, rspi_result and rspi_zero stay stable until rspi_valid & rspi_ready. On that handshake, rspi_valid clears at the next edge; result and zero keep their last values.
- last_grant updates only on an actual grant. Idle cycles do not rotate priority.
- Throughput:
  - A single port with rsp_ready held high achieves 1 accept per 2 cycles (accept T, response T+1, re-grant T+2).
  - Two active ports alternate, giving 1 ALU operation per cycle.
- Arithmetic and flags are entirely the ALU's:
  - Wrap-around is modulo 2^DATA_WIDTH.
  - Zero is 1 only for SUB with a zero result; it is 0 for AND/OR/ADD even when the result is 0. The arbiter passes alu_zero through unmodified.
- Requesters must hold valid and operands stable until ready. Dropping valid before ready is legal and simply withdraws the request; no state changes.
- Reset mid-operation: pending responses are discarded (rsp*_valid=0 after the edge). In-flight requests are not accepted in the reset cycle.

Decomposition:
- Shared package alu_pkg:
  - ALU control constants: ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11.
  - ALU_CTRL_W=2 and DATA_WIDTH default 32.
- One natural sub-module: alu_rsp_slot, the per-port response register (valid/result/zero with hold-until-ready). It is instantiated twice. Arbitration logic stays in the top.

Test Plan:
- Single ADD: req0 ADD 5+7, rsp0_ready=1 → req0_ready=1 at T; rsp0_valid=1, rsp0_result=12, rsp0_zero=0 at T+1; rsp0_valid=0 at T+2.
- Tie after reset (PRIORITY_RESET=0): req0 SUB 9-9 and req1 OR 0xF0|0x0F, both held → T grants port 0 (rsp0 result 0, zero 1); T+1 grants port 1 (rsp1 result 0xFF, zero 0); req1_ready=0 at T.
- Backpressure: rsp0_ready=0, req0 ADD 1+1 repeatedly → first accept, then req0_ready=0 and rsp0_result=2 held for 5 cycles. Raise rsp0_ready → rsp0_valid drops next edge; req0 re-granted the cycle after.
- Wrap/flags: SUB 0-1 → result 0xFFFFFFFF, zero 0. ADD 0xFFFFFFFF+1 → result 0, zero 0. AND 0xA & 0x5 → result 0, zero 0.
- Sustained contention: both ports valid for 8 cycles, both rsp_ready=1 → grants 0,1,0,1,…; exactly one ALU operation per cycle; no port starved.
- Reset mid-operation: rsp1_valid=1 pending, assert reset 1 cycle with both reqs valid → rsp*_valid=0, no accept in reset cycle; first grant after reset goes to port PRIORITY_RESET.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU and everything that drives it.
// Control encodings match the ALU's ALUControl input.
package alu_pkg;

  localparam int ALU_CTRL_W     = 2;
  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 2'b00;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 2'b01;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 2'b10;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 2'b11;

  // Port indices used for the round-robin pointer.
  localparam logic PORT_EXEC   = 1'b0;
  localparam logic PORT_BRANCH = 1'b1;

endpackage

// File: rtl/alu_rsp_slot.sv
// One port's response register: captures the ALU result and zero flag
// and holds them until the consumer takes the response.
module alu_rsp_slot
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  zero_in,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  // capture never coincides with valid=1: the arbiter does not grant a
  // port whose response is still outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else if (capture) begin
      valid  <= 1'b1;
      result <= result_in;
      zero   <= zero_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute datapath (port 0)
// and the branch/address unit (port 1) with round-robin arbitration.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = ALU_DATA_WIDTH,
  parameter int PRIORITY_RESET = 0
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [ALU_CTRL_W-1:0] req0_ctrl,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp0_zero,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [ALU_CTRL_W-1:0] req1_ctrl,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  rsp1_zero,

  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both 1. Requesters hold valid and payload stable until ready; ready may
  // depend combinationally on valid. Responses hold until rsp_ready.

  localparam logic LAST_GRANT_RESET = (PRIORITY_RESET == 0) ? PORT_BRANCH : PORT_EXEC;

  logic last_grant;
  logic elig0, elig1;
  logic grant0, grant1;

  // A port with an outstanding response is never eligible, even when the
  // response is being consumed this same cycle.
  assign elig0 = req0_valid & ~rsp0_valid;
  assign elig1 = req1_valid & ~rsp1_valid;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (elig0 && elig1) begin
        grant0 = (last_grant == PORT_BRANCH);
        grant1 = (last_grant == PORT_EXEC);
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = ALU_AND;
    if (grant0) begin
      alu_op1  = req0_op1;
      alu_op2  = req0_op2;
      alu_ctrl = req0_ctrl;
    end else if (grant1) begin
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
      alu_ctrl = req1_ctrl;
    end
  end

  // Priority rotates only on a real grant; idle cycles keep the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_GRANT_RESET;
    end else if (grant0) begin
      last_grant <= PORT_EXEC;
    end else if (grant1) begin
      last_grant <= PORT_BRANCH;
    end
  end

  alu_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .capture   (grant0),
    .result_in (alu_result),
    .zero_in   (alu_zero),
    .ready     (rsp0_ready),
    .valid     (rsp0_valid),
    .result    (rsp0_result),
    .zero      (rsp0_zero)
  );

  alu_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .capture   (grant1),
    .result_in (alu_result),
    .zero_in   (alu_zero),
    .ready     (rsp1_ready),
    .valid     (rsp1_valid),
    .result    (rsp1_result),
    .zero      (rsp1_zero)
  );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached
// to the shared ALU pins.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready;
  logic [W-1:0]  req0_op1, req0_op2;
  logic [1:0]    req0_ctrl;
  logic          rsp0_valid, rsp0_ready, rsp0_zero;
  logic [W-1:0]  rsp0_result;
  logic          req1_valid, req1_ready;
  logic [W-1:0]  req1_op1, req1_op2;
  logic [1:0]    req1_ctrl;
  logic          rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0]  rsp1_result;
  logic [W-1:0]  alu_op1, alu_op2, alu_result;
  logic [1:0]    alu_ctrl;
  logic          alu_zero;

  int checks = 0;
  int errors = 0;
  int grants0 = 0;
  int grants1 = 0;

  alu_share_arbiter #(.DATA_WIDTH(W), .PRIORITY_RESET(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op1    (req0_op1),
    .req0_op2    (req0_op2),
    .req0_ctrl   (req0_ctrl),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op1    (req1_op1),
    .req1_op2    (req1_op2),
    .req1_ctrl   (req1_ctrl),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    case (alu_ctrl)
      ALU_AND: alu_result = alu_op1 & alu_op2;
      ALU_OR:  alu_result = alu_op1 | alu_op2;
      ALU_ADD: alu_result = alu_op1 + alu_op2;
      default: alu_result = alu_op1 - alu_op2;
    endcase
    alu_zero = (alu_ctrl == ALU_SUB) && (alu_result == '0);
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Port 1 single operation with hand-computed result and zero flag.
  task automatic op_port1(input string tag, input logic [1:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_zero);
    req1_valid = 1'b1;
    req1_ctrl  = ctrl;
    req1_op1   = a;
    req1_op2   = b;
    #1;
    chk({tag, "_ready"}, {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, {31'd0, rsp1_valid}, 32'd1);
    chk({tag, "_result"}, rsp1_result, exp_res);
    chk({tag, "_zero"}, {31'd0, rsp1_zero}, {31'd0, exp_zero});
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_ctrl = 2'b00;
    req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_ctrl = 2'b00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    chk("reset_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
    chk("idle_alu_op1", alu_op1, 32'd0);
    tick();

    // Single ADD on port 0
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_op1 = 32'd5; req0_op2 = 32'd7;
    #1;
    chk("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("add_alu_op1", alu_op1, 32'd5);
    chk("add_alu_ctrl", {30'd0, alu_ctrl}, 32'd2);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_rsp0_result", rsp0_result, 32'd12);
    chk("add_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
    tick();
    chk("add_rsp0_cleared", {31'd0, rsp0_valid}, 32'd0);

    // Tie right after reset: port 0 wins first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_ctrl = ALU_SUB; req0_op1 = 32'd9;   req0_op2 = 32'd9;
    req1_valid = 1'b1; req1_ctrl = ALU_OR;  req1_op1 = 32'hF0;  req1_op2 = 32'h0F;
    #1;
    chk("tie_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("tie_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("tie_alu_ctrl", {30'd0, alu_ctrl}, 32'd3);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("tie_req1_ready_t1", {31'd0, req1_ready}, 32'd1);
    chk("tie_alu_op1_t1", alu_op1, 32'hF0);
    chk("tie_rsp0_result", rsp0_result, 32'd0);
    chk("tie_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("tie_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("tie_rsp1_result", rsp1_result, 32'hFF);
    chk("tie_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
    chk("tie_rsp0_cleared", {31'd0, rsp0_valid}, 32'd0);
    tick();

    // Backpressure on port 0
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_op1 = 32'd1; req0_op2 = 32'd1;
    #1;
    chk("bp_first_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_ready", {31'd0, req0_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("bp_hold_result", rsp0_result, 32'd2);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_no_bypass", {31'd0, req0_ready}, 32'd0);
    tick();
    chk("bp_rsp0_dropped", {31'd0, rsp0_valid}, 32'd0);
    chk("bp_regrant", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("bp_second_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("bp_second_result", rsp0_result, 32'd2);
    tick();

    // Wrap-around and zero-flag corners on port 1
    op_port1("sub_0_1", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    op_port1("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    op_port1("and_zero", ALU_AND, 32'hA, 32'h5, 32'd0, 1'b0);

    // Sustained contention: strict alternation starting with port 0
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_op1 = i; req0_op2 = 32'd1;
      req1_valid = 1'b1; req1_ctrl = ALU_SUB; req1_op1 = 32'd100; req1_op2 = i;
      #1;
      chk("rr_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_req1_ready", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_alu_ctrl", {30'd0, alu_ctrl}, (i % 2 == 0) ? 32'd2 : 32'd3);
      if (req0_ready) grants0++;
      if (req1_ready) grants1++;
      tick();
    end
    chk("rr_grants0", grants0, 32'd4);
    chk("rr_grants1", grants1, 32'd4);
    chk("rr_last_rsp1_result", rsp1_result, 32'd93);

    // Reset with port 1 response pending and both requests valid
    rsp1_ready = 1'b0;
    chk("rst_pending_rsp1", {31'd0, rsp1_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    reset = 1'b0;
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    #1;
    chk("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("post_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("post_rst_rsp0_result", rsp0_result, 32'd8);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
